// File: rtl/instr_register_pkg.sv
// Shared opcode encoding and default widths for the instruction register.
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    localparam int OPW_DEF   = 32;
    localparam int DEPTH_DEF = 32;

endpackage

// File: rtl/instr_alu.sv
// Combinational result unit between S1 and S2.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  opcode_t                  opc,
    input  logic signed [OPW-1:0]    a,
    input  logic signed [OPW-1:0]    b,
    output logic signed [2*OPW-1:0]  result,
    output logic                     err
);

    logic signed [2*OPW-1:0] ae;
    logic signed [2*OPW-1:0] be;
    logic signed [2*OPW-1:0] bd;
    logic                    bz;

    assign ae = {{OPW{a[OPW-1]}}, a};
    assign be = {{OPW{b[OPW-1]}}, b};
    assign bz = (b == '0);
    // Divisor forced to 1 on zero so the divider never sees b==0.
    assign bd = bz ? be + 1'b1 : be;

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (opc)
            ZERO:  result = '0;
            PASSA: result = ae;
            PASSB: result = be;
            ADD:   result = ae + be;
            SUB:   result = ae - be;
            MULT:  result = ae * be;
            DIV: begin
                if (bz) err = 1'b1;
                else    result = ae / bd;
            end
            MOD: begin
                if (bz) err = 1'b1;
                else    result = ae % bd;
            end
        endcase
    end

endmodule

// File: rtl/instr_register_gen.sv
// Instruction register with a one-stage compute pipeline,
// write-first reads and occupancy tracking.
module instr_register_gen
    import instr_register_pkg::*;
#(
    parameter int OPW      = OPW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter bit AUTO_INC = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_en,
    input  opcode_t              opcode,
    input  logic signed [OPW-1:0] operand_a,
    input  logic signed [OPW-1:0] operand_b,
    input  logic [AW-1:0]        write_pointer,
    input  logic                 read_en,
    input  logic [AW-1:0]        read_pointer,
    output logic [4*OPW+3:0]     instruction_word,
    output logic                 rd_valid,
    output logic [AW:0]          count,
    output logic                 full
);

    typedef struct packed {
        opcode_t                 opc;
        logic signed [OPW-1:0]   op_a;
        logic signed [OPW-1:0]   op_b;
        logic signed [2*OPW-1:0] result;
        logic                    err;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t                  mem [DEPTH];
    logic [DEPTH-1:0]        written;
    entry_t                  rd_q;
    entry_t                  wr_entry;

    logic                    s1_valid;
    opcode_t                 s1_opc;
    logic signed [OPW-1:0]   s1_a;
    logic signed [OPW-1:0]   s1_b;
    logic [AW-1:0]           s1_addr;
    logic [AW-1:0]           wptr;

    logic signed [2*OPW-1:0] alu_res;
    logic                    alu_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_opc   <= ZERO;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_addr  <= '0;
            wptr     <= '0;
        end else begin
            s1_valid <= load_en;
            if (load_en) begin
                s1_opc  <= opcode;
                s1_a    <= operand_a;
                s1_b    <= operand_b;
                s1_addr <= AUTO_INC ? wptr : write_pointer;
                if (AUTO_INC) wptr <= wptr + 1'b1;
            end
        end
    end

    instr_alu #(
        .OPW(OPW)
    ) u_alu (
        .opc    (s1_opc),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_res),
        .err    (alu_err)
    );

    always_comb begin
        wr_entry = '{
            opc:    s1_opc,
            op_a:   s1_a,
            op_b:   s1_b,
            result: alu_res,
            err:    alu_err
        };
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            written <= '0;
            count   <= '0;
        end else if (s1_valid) begin
            mem[s1_addr]     <= wr_entry;
            written[s1_addr] <= 1'b1;
            if (!written[s1_addr] && count != DEPTH_C)
                count <= count + 1'b1;
        end
    end

    // Bypass the committing entry so a same-edge read sees new data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= read_en;
            if (read_en) begin
                if (s1_valid && s1_addr == read_pointer)
                    rd_q <= wr_entry;
                else
                    rd_q <= mem[read_pointer];
            end
        end
    end

    assign instruction_word = rd_q;
    assign full             = (count == DEPTH_C);

endmodule

// File: tb/tb_instr_register_gen.sv
// Bench: two instances (direct and auto-increment) against a
// per-entry behavioural model.
module tb_instr_register_gen;
    import instr_register_pkg::*;

    typedef struct packed {
        logic [2:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        err;
    } ent_t;

    typedef struct {
        opcode_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  addr;
        logic [63:0] res;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          le  [2];
    opcode_t       opc [2];
    logic [31:0]   a   [2];
    logic [31:0]   b   [2];
    logic [4:0]    wp  [2];
    logic [4:0]    rp  [2];
    logic          re  [2];
    logic [131:0]  word[2];
    logic          rv  [2];
    logic          full[2];
    logic [5:0]    cnt0;
    logic [2:0]    cnt1;

    instr_register_gen #(.OPW(32), .DEPTH(32), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_en(le[0]), .opcode(opc[0]),
        .operand_a(a[0]), .operand_b(b[0]), .write_pointer(wp[0]),
        .read_en(re[0]), .read_pointer(rp[0]),
        .instruction_word(word[0]), .rd_valid(rv[0]),
        .count(cnt0), .full(full[0])
    );

    instr_register_gen #(.OPW(32), .DEPTH(4), .AUTO_INC(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_en(le[1]), .opcode(opc[1]),
        .operand_a(a[1]), .operand_b(b[1]), .write_pointer(wp[1][1:0]),
        .read_en(re[1]), .read_pointer(rp[1][1:0]),
        .instruction_word(word[1]), .rd_valid(rv[1]),
        .count(cnt1), .full(full[1])
    );

    // Model state: memory image, written set, in-flight load
    ent_t mm [2][32];
    bit   wr [2][32];
    bit   pv [2];
    int   pa [2];
    ent_t pe [2];
    int   wptr[2];
    ent_t ew [2];
    bit   erv[2];
    int   dep  [2] = '{32, 4};
    int   autoi[2] = '{0, 1};

    int checks   = 0;
    int failures = 0;

    function automatic ent_t mk(opcode_t o, logic [31:0] x, logic [31:0] y);
        longint sa = longint'(signed'(x));
        longint sb = longint'(signed'(y));
        longint r  = 0;
        bit     e  = 1'b0;
        case (o)
            ZERO:  r = 0;
            PASSA: r = sa;
            PASSB: r = sb;
            ADD:   r = sa + sb;
            SUB:   r = sa - sb;
            MULT:  r = sa * sb;
            DIV:   if (sb == 0) e = 1'b1; else r = sa / sb;
            MOD:   if (sb == 0) e = 1'b1; else r = sa % sb;
            default: r = 0;
        endcase
        return '{opc: o, a: x, b: y, res: r, err: e};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                mm[m][i] = '0;
                wr[m][i] = 1'b0;
            end
            pv[m]   = 1'b0;
            pa[m]   = 0;
            pe[m]   = '0;
            wptr[m] = 0;
            ew[m]   = '0;
            erv[m]  = 1'b0;
        end
    endtask

    task automatic model_edge(int m);
        if (pv[m]) begin
            mm[m][pa[m]] = pe[m];
            wr[m][pa[m]] = 1'b1;
        end
        erv[m] = re[m];
        if (re[m]) ew[m] = mm[m][int'(rp[m]) % dep[m]];
        pv[m] = le[m];
        if (le[m]) begin
            pa[m] = autoi[m] ? wptr[m] : int'(wp[m]) % dep[m];
            pe[m] = mk(opc[m], a[m], b[m]);
            if (autoi[m]) wptr[m] = (wptr[m] + 1) % dep[m];
        end
    endtask

    function automatic int exp_cnt(int m);
        int n = 0;
        for (int i = 0; i < dep[m]; i++) n += wr[m][i];
        return n;
    endfunction

    task automatic chk(string nm, logic [131:0] act, logic [131:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, ex);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [5:0] c = (m == 0) ? cnt0 : {3'b0, cnt1};
            chk($sformatf("word%0d", m), word[m], ew[m]);
            chk($sformatf("rd_valid%0d", m), rv[m], erv[m]);
            chk($sformatf("count%0d", m), c, 132'(exp_cnt(m)));
            chk($sformatf("full%0d", m), full[m], exp_cnt(m) == dep[m]);
        end
    endtask

    task automatic cycle();
        for (int m = 0; m < 2; m++) model_edge(m);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        for (int m = 0; m < 2; m++) begin
            le[m]  = 1'b0;
            re[m]  = 1'b0;
            opc[m] = ZERO;
            a[m]   = '0;
            b[m]   = '0;
            wp[m]  = '0;
            rp[m]  = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load(int m, opcode_t o, logic [31:0] x, logic [31:0] y, int ad);
        le[m]  = 1'b1;
        opc[m] = o;
        a[m]   = x;
        b[m]   = y;
        wp[m]  = 5'(ad);
    endtask

    vec_t tbl[10];
    ent_t w;

    initial begin
        tbl[0] = '{ADD,   32'd5,          -32'sd3,     5'd2,  64'd2, 1'b0};
        tbl[1] = '{MULT,  32'h7FFFFFFF,   32'd2,       5'd4,  64'h00000000_FFFFFFFE, 1'b0};
        tbl[2] = '{DIV,   32'd7,          32'd0,       5'd5,  64'd0, 1'b1};
        tbl[3] = '{MOD,   32'd9,          32'd0,       5'd6,  64'd0, 1'b1};
        tbl[4] = '{SUB,   32'd3,          32'd10,      5'd7,  -64'sd7, 1'b0};
        tbl[5] = '{DIV,   -32'sd7,        32'd2,       5'd8,  -64'sd3, 1'b0};
        tbl[6] = '{MOD,   -32'sd7,        32'd2,       5'd9,  -64'sd1, 1'b0};
        tbl[7] = '{PASSA, 32'hFFFFFFFF,   32'd1,       5'd10, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        tbl[8] = '{PASSB, 32'd1,          32'h80000000, 5'd31, 64'hFFFFFFFF_80000000, 1'b0};
        tbl[9] = '{MULT,  -32'sd2,        32'd3,       5'd0,  -64'sd6, 1'b0};

        idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_word", word[0], '0);
        chk("reset_count", cnt0, '0);
        chk("reset_full", full[0], 1'b0);
        chk("reset_rv", rv[0], 1'b0);
        reset_n = 1'b1;

        re[0] = 1'b1;
        re[1] = 1'b1;
        cycle();
        chk("rd0_word", word[0], '0);
        chk("rd0_valid", rv[0], 1'b1);
        idle();

        for (int i = 0; i < 10; i++) begin
            load(0, tbl[i].op, tbl[i].a, tbl[i].b, int'(tbl[i].addr));
            cycle();
            idle();
            re[0] = 1'b1;
            rp[0] = tbl[i].addr;
            cycle();
            w = ent_t'(word[0]);
            chk($sformatf("vec%0d_res", i), w.res, tbl[i].res);
            chk($sformatf("vec%0d_err", i), w.err, tbl[i].err);
            idle();
        end

        for (int k = 0; k < 6; k++) begin
            load(1, ADD, 32'(100 + k), 32'(k), 0);
            cycle();
            if (k == 3) chk("auto_full_before", full[1], 1'b0);
            if (k == 4) chk("auto_full_after4", full[1], 1'b1);
        end
        idle();
        cycle();
        chk("auto_count", cnt1, 3'd4);
        re[1] = 1'b1;
        rp[1] = 5'd0;
        cycle();
        w = ent_t'(word[1]);
        chk("auto_entry0_a", w.a, 32'd104);
        rp[1] = 5'd1;
        cycle();
        w = ent_t'(word[1]);
        chk("auto_entry1_a", w.a, 32'd105);
        idle();

        do_reset();
        load(0, PASSA, 32'd11, 32'd0, 3);
        cycle();
        load(0, PASSA, 32'd22, 32'd0, 3);
        cycle();
        load(0, PASSA, 32'd33, 32'd0, 3);
        cycle();
        idle();
        cycle();
        re[0] = 1'b1;
        rp[0] = 5'd3;
        cycle();
        w = ent_t'(word[0]);
        chk("rewrite_last", w.a, 32'd33);
        chk("rewrite_count", cnt0, 6'd1);
        idle();

        load(0, ADD, 32'd1, 32'd2, 9);
        cycle();
        idle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_word", word[0], '0);
        chk("midrst_count", cnt0, '0);
        chk("midrst_full", full[0], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        re[0] = 1'b1;
        rp[0] = 5'd9;
        cycle();
        chk("midrst_entry9", word[0], '0);
        chk("midrst_count2", cnt0, '0);
        idle();

        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                le[m]  = 1'($urandom_range(0, 1));
                opc[m] = opcode_t'($urandom_range(0, 7));
                a[m]   = ($urandom_range(0, 3) == 0) ?
                         32'($urandom_range(0, 20)) - 32'd10 : $urandom;
                b[m]   = ($urandom_range(0, 3) == 0) ?
                         32'($urandom_range(0, 4)) - 32'd2 : $urandom;
                wp[m]  = 5'($urandom_range(0, dep[m] - 1));
                re[m]  = 1'($urandom_range(0, 1));
                rp[m]  = 5'($urandom_range(0, dep[m] - 1));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_register_gen.md
# instr_register_gen

Parametrised next-generation instruction register. It stores up to DEPTH instruction entries, each holding opcode, two signed operands and a computed result. Compared with the fixed instr_register it adds a one-stage compute pipeline, error flagging, an auto-increment write mode, and occupancy status. It sits under the top-level netlist in place of instr_register and is driven by the testbench interface, which is clocked on the same clk.

## Interface
- OPW, 32: operand width in bits, signed.
- DEPTH, 32: number of entries, power of two, ≥2; AW = $clog2(DEPTH).
- AUTO_INC, 0: 1 = internal write pointer; write_pointer input is ignored.

- clk  in  1: rising-edge clock.
- reset_n  in  1: asynchronous, active-low reset.
- load_en  in  1: load request, sampled at posedge.
- opcode  in  opcode_t: operation.
- operand_a  in  OPW: signed operand A.
- operand_b  in  OPW: signed operand B.
- write_pointer  in  AW: write address (AUTO_INC=0 only).
- read_en  in  1: read request.
- read_pointer  in  AW: read address.
- instruction_word  out  entry_t: read data {opc, op_a, op_b, result[2*OPW], err}.
- rd_valid  out  1: instruction_word updated this cycle.
- count  out  AW+1: number of distinct entries written since reset, saturating at DEPTH.
- full  out  1: count == DEPTH.

## Operation
- Stage S1: on posedge with load_en=1, capture opcode, operands and address (write_pointer, or internal wptr if AUTO_INC=1) into the S1 register and set s1_valid.
- Stage S2: on the next posedge with s1_valid=1, write {opc, a, b, result, err} into mem[addr].
- Results use signed arithmetic and are sign-extended to 2*OPW:
  - ZERO → 0; PASSA → a; PASSB → b; ADD → a+b; SUB → a−b; MULT → a*b (full 2*OPW); DIV → a/b; MOD → a%b.
- DIV or MOD with b==0: result 0, err=1. For every other case err=0.
- AUTO_INC=1: wptr increments on each accepted load and wraps from DEPTH−1 to 0.
- count increments when an address is written for the first time since reset (per-entry written bit) and saturates at DEPTH. Rewriting an address does not change count.
- Read: on posedge with read_en=1, instruction_word ← mem[read_pointer] and rd_valid=1. Otherwise rd_valid=0 and instruction_word holds its value.
- Loads on back-to-back cycles are fully pipelined, one entry per cycle. There is no backpressure.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears all mem entries, all written bits, the S1 register, s1_valid and wptr. Outputs after reset: instruction_word=0 (opc=ZERO), rd_valid=0, count=0, full=0.
- Write latency: load_en sampled at edge E0 commits to mem at edge E1.
- Read latency: 1 cycle. read_en at edge E drives the new instruction_word after E.
- Write-first: a read at E1 of the address being committed at E1 returns the new entry.
- Two loads in flight to the same address: the later load wins.
- Reset asserted while s1_valid=1: the in-flight entry is discarded.
- full asserts in the cycle after the commit that makes count=DEPTH.

## Structure
- instr_register_pkg holds opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD) and the default width constants.
- entry_t is a packed struct typedef'd inside the module, because its width depends on OPW.
- Sub-module instr_alu is purely combinational, parameterised by OPW. It takes {opc, a, b} and produces {result, err}, and is instantiated between S1 and S2.
- tb_ifc is extended with read_en, rd_valid, count and full. The top-level netlist connects them by name.

## Test plan
- Reset then read addr 0 → instruction_word all zero, count=0, full=0, rd_valid=1.
- Load ADD a=5, b=−3 at addr 2, then read addr 2 at the commit edge → result=2, err=0 (write-first).
- Load MULT a=0x7FFFFFFF, b=2 → result=0x00000000_FFFFFFFE; load DIV a=7, b=0 → result=0, err=1.
- AUTO_INC=1, DEPTH=4, six loads → entries land at 0,1,2,3,0,1; count=4, full=1 after the 4th commit; entry 0 holds the 5th load.
- Rewrite addr 3 three times with AUTO_INC=0 → count=1; the last write is visible.
- Assert reset_n=0 mid-cycle, one cycle after a load → outputs clear immediately, the target entry stays zero, count=0.
